// File: rtl/alu_disp_pkg.sv
// Shared definitions for the ALU board seven-segment display controller.
// Holds glyph indices and segment codes, anode patterns, the view-state
// enumeration and the operand-nibble to glyph helper.
package alu_disp_pkg;

  // Digit content: 0-9 are decimal digits, 10 is minus, 11 is blank.
  typedef logic [3:0] glyph_t;

  localparam glyph_t GLY_MINUS = 4'd10;
  localparam glyph_t GLY_BLANK = 4'd11;

  // Segment codes a..g, a is the MSB, active-low.
  localparam logic [6:0] SEG_0     = 7'b0000001;
  localparam logic [6:0] SEG_1     = 7'b1001111;
  localparam logic [6:0] SEG_2     = 7'b0010010;
  localparam logic [6:0] SEG_3     = 7'b0000110;
  localparam logic [6:0] SEG_4     = 7'b1001100;
  localparam logic [6:0] SEG_5     = 7'b0100100;
  localparam logic [6:0] SEG_6     = 7'b0100000;
  localparam logic [6:0] SEG_7     = 7'b0001111;
  localparam logic [6:0] SEG_8     = 7'b0000000;
  localparam logic [6:0] SEG_9     = 7'b0000100;
  localparam logic [6:0] SEG_MINUS = 7'b1111110;
  localparam logic [6:0] SEG_BLANK = 7'b1111111;

  // Anode enables, active-low, bit 3 is the leftmost digit (digit 0).
  localparam logic [3:0] AN_OFF  = 4'b1111;
  localparam logic [3:0] AN_DIG0 = 4'b0111;
  localparam logic [3:0] AN_DIG1 = 4'b1011;
  localparam logic [3:0] AN_DIG2 = 4'b1101;
  localparam logic [3:0] AN_DIG3 = 4'b1110;

  typedef enum logic {
    V_OPER = 1'b0,
    V_RES  = 1'b1
  } view_state_e;

  function automatic logic [3:0] anode_for(input logic [1:0] idx);
    logic [3:0] an;
    case (idx)
      2'd0:    an = AN_DIG0;
      2'd1:    an = AN_DIG1;
      2'd2:    an = AN_DIG2;
      default: an = AN_DIG3;
    endcase
    return an;
  endfunction

  // Returns {tens, ones} glyphs for one operand nibble.
  // Signed negative nibbles show minus plus magnitude (1000 -> 8).
  function automatic logic [7:0] nibble_glyphs(input logic [3:0] nib,
                                               input logic       is_signed);
    glyph_t tens;
    glyph_t ones;
    if (is_signed && nib[3]) begin
      tens = GLY_MINUS;
      ones = ~nib + 4'd1;
    end else if (is_signed) begin
      tens = GLY_BLANK;
      ones = nib;
    end else if (nib > 4'd9) begin
      tens = 4'd1;
      ones = nib - 4'd10;
    end else begin
      tens = 4'd0;
      ones = nib;
    end
    return {tens, ones};
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Glyph index to seven-segment code, active-low, a = MSB.
// Ports:
//   glyph   in  4  glyph index (0-9 digits, 10 minus, 11 blank)
//   a_to_g  out 7  segment pattern; any unlisted index decodes to blank
module seg7_decode
  import alu_disp_pkg::*;
(
  input  glyph_t     glyph,
  output logic [6:0] a_to_g
);

  always_comb begin
    a_to_g = SEG_BLANK;
    case (glyph)
      4'd0:      a_to_g = SEG_0;
      4'd1:      a_to_g = SEG_1;
      4'd2:      a_to_g = SEG_2;
      4'd3:      a_to_g = SEG_3;
      4'd4:      a_to_g = SEG_4;
      4'd5:      a_to_g = SEG_5;
      4'd6:      a_to_g = SEG_6;
      4'd7:      a_to_g = SEG_7;
      4'd8:      a_to_g = SEG_8;
      4'd9:      a_to_g = SEG_9;
      GLY_MINUS: a_to_g = SEG_MINUS;
      default:   a_to_g = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/alu_disp_ctrl.sv
// Scan controller and view arbiter for the 4-digit common-anode display.
// Multiplexes the digits with a blanking gap at the start of every slot,
// latches content once per frame, and switches between the operand view
// and a result view held for HOLD_FRAMES frames after each result.
// Ports:
//   CLK           in  1  system clock
//   RST           in  1  synchronous active-high reset
//   operands      in  8  [7:4] A nibble, [3:0] B nibble
//   result        in  8  ALU result byte
//   result_valid  in  1  one-cycle pulse, result is new
//   isSigned      in  1  show values as two's complement
//   SF            in  1  ALU sign flag, sampled with result
//   seg           out 4  anode enables, active-low, seg[3] leftmost
//   a_to_g        out 7  segments a..g, active-low
//   view_res      out 1  result view is on the display
//
// state  | meaning
// V_OPER | operand nibbles shown, snapshot refreshed every frame
// V_RES  | captured result shown, hold counts remaining frames
module alu_disp_ctrl
  import alu_disp_pkg::*;
#(
  parameter int DIV         = 100000,
  parameter int BLANK       = 1000,
  parameter int HOLD_FRAMES = 250
)(
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] operands,
  input  logic [7:0] result,
  input  logic       result_valid,
  input  logic       isSigned,
  input  logic       SF,
  output logic [3:0] seg,
  output logic [6:0] a_to_g,
  output logic       view_res
);

  localparam int CW = $clog2(DIV);
  localparam int HW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIV - 1);
  localparam logic [CW-1:0] CNT_BLANK = CW'(BLANK);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLD_FRAMES - 1);

  logic [CW-1:0] cnt;
  logic [1:0]    idx;
  logic          slot_end;
  logic          frame_end;

  view_state_e   state, state_nxt;
  logic [HW-1:0] hold, hold_nxt;
  glyph_t [3:0]  snap, snap_nxt;

  logic          pend;
  logic [7:0]    pend_res;
  logic          pend_sf;

  glyph_t [3:0]  oper_snap;
  glyph_t [3:0]  res_snap;
  logic [7:0]    a_gly, b_gly;
  logic [7:0]    res_src, res_mag;
  logic          sf_src, res_neg, new_res;
  glyph_t        res_hun, res_ten, res_one;

  logic          in_blank;
  glyph_t        glyph_sel;
  logic [6:0]    seg_code;

  assign slot_end  = (cnt == CNT_LAST);
  assign frame_end = slot_end && (idx == 2'd3);
  assign new_res   = result_valid || pend;

  // Operand view content.
  assign a_gly = nibble_glyphs(operands[7:4], isSigned);
  assign b_gly = nibble_glyphs(operands[3:0], isSigned);

  always_comb begin
    oper_snap    = '0;
    oper_snap[0] = a_gly[7:4];
    oper_snap[1] = a_gly[3:0];
    oper_snap[2] = b_gly[7:4];
    oper_snap[3] = b_gly[3:0];
  end

  // Result view content; a pulse in the boundary cycle overrides pending.
  always_comb begin
    res_src = result_valid ? result : pend_res;
    sf_src  = result_valid ? SF : pend_sf;
    res_neg = isSigned && sf_src;
    res_mag = res_neg ? (~res_src + 8'd1) : res_src;
    res_hun = 4'(res_mag / 8'd100);
    res_ten = 4'((res_mag / 8'd10) % 8'd10);
    res_one = 4'(res_mag % 8'd10);

    res_snap    = '0;
    res_snap[0] = res_neg ? GLY_MINUS : GLY_BLANK;
    res_snap[1] = (res_hun == 4'd0) ? GLY_BLANK : res_hun;
    res_snap[2] = (res_hun == 4'd0 && res_ten == 4'd0) ? GLY_BLANK : res_ten;
    res_snap[3] = res_one;
  end

  // View FSM next state; only acts on frame boundaries.
  always_comb begin
    state_nxt = state;
    hold_nxt  = hold;
    snap_nxt  = snap;
    if (frame_end) begin
      if (new_res) begin
        state_nxt = V_RES;
        hold_nxt  = HOLD_LOAD;
        snap_nxt  = res_snap;
      end else if (state == V_RES && hold != '0) begin
        hold_nxt = hold - HW'(1);
      end else begin
        state_nxt = V_OPER;
        snap_nxt  = oper_snap;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= V_OPER;
      hold     <= '0;
      snap     <= '0;
      view_res <= 1'b0;
    end else begin
      state    <= state_nxt;
      hold     <= hold_nxt;
      snap     <= snap_nxt;
      view_res <= (state_nxt == V_RES);
    end
  end

  // Scan timing and result capture.
  always_ff @(posedge CLK) begin
    if (RST) begin
      cnt      <= '0;
      idx      <= 2'd0;
      pend     <= 1'b0;
      pend_res <= 8'd0;
      pend_sf  <= 1'b0;
    end else begin
      cnt <= slot_end ? '0 : cnt + CW'(1);
      if (slot_end) idx <= idx + 2'd1;

      if (frame_end && new_res) begin
        pend <= 1'b0;
      end else if (result_valid) begin
        pend     <= 1'b1;
        pend_res <= result;
        pend_sf  <= SF;
      end
    end
  end

  // Output stage, one cycle behind cnt/idx.
  assign in_blank  = (cnt < CNT_BLANK);
  assign glyph_sel = in_blank ? GLY_BLANK : snap[idx];

  seg7_decode u_dec (
    .glyph  (glyph_sel),
    .a_to_g (seg_code)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      seg    <= AN_OFF;
      a_to_g <= SEG_BLANK;
    end else begin
      seg    <= in_blank ? AN_OFF : anode_for(idx);
      a_to_g <= seg_code;
    end
  end

endmodule

// File: tb/tb_alu_disp_ctrl.sv
module tb_alu_disp_ctrl;

  localparam logic [6:0] G0 = 7'b0000001;
  localparam logic [6:0] G1 = 7'b1001111;
  localparam logic [6:0] G2 = 7'b0010010;
  localparam logic [6:0] G3 = 7'b0000110;
  localparam logic [6:0] G4 = 7'b1001100;
  localparam logic [6:0] G5 = 7'b0100100;
  localparam logic [6:0] G6 = 7'b0100000;
  localparam logic [6:0] G7 = 7'b0001111;
  localparam logic [6:0] G8 = 7'b0000000;
  localparam logic [6:0] G9 = 7'b0000100;
  localparam logic [6:0] GM = 7'b1111110;
  localparam logic [6:0] GB = 7'b1111111;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic [7:0] operands = 8'h00;
  logic [7:0] result = 8'h00;
  logic       result_valid = 1'b0;
  logic       isSigned = 1'b0;
  logic       SF = 1'b0;
  logic [3:0] seg;
  logic [6:0] a_to_g;
  logic       view_res;

  int total = 0;
  int bad = 0;
  int k = 0;

  alu_disp_ctrl #(.DIV(8), .BLANK(2), .HOLD_FRAMES(3)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .operands     (operands),
    .result       (result),
    .result_valid (result_valid),
    .isSigned     (isSigned),
    .SF           (SF),
    .seg          (seg),
    .a_to_g       (a_to_g),
    .view_res     (view_res)
  );

  always #5 CLK = ~CLK;

  // Edges since reset release; output after edge k reflects slot position k-1.
  always @(posedge CLK) begin
    if (RST) k <= 0;
    else     k <= k + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    logic [7:0] ops;
    logic       sgn;
    logic [6:0] d0, d1, d2, d3;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_mod(input int m);
    int n;
    n = 0;
    do begin
      @(negedge CLK);
      n++;
    end while ((k % 32) != m && n < 40);
    if ((k % 32) != m) begin
      total++;
      bad++;
      $display("FAIL frame_sync: k=%0d, want k mod 32 = %0d", k, m);
    end
  endtask

  task automatic pulse(input logic [7:0] r, input logic sf);
    result       = r;
    SF           = sf;
    result_valid = 1'b1;
    @(negedge CLK);
    result_valid = 1'b0;
  endtask

  // Checks one whole frame (32 samples). Caller is either at frame
  // position 0 already (skip_wait) or before the next one.
  task automatic check_frame(input logic [6:0] e0, input logic [6:0] e1,
                             input logic [6:0] e2, input logic [6:0] e3,
                             input logic ev, input bit skip_wait,
                             input string nm);
    logic [6:0] ex[4];
    bit         ok[4];
    logic [3:0] es;
    logic [6:0] eg;
    int         di, p;
    ex[0] = e0; ex[1] = e1; ex[2] = e2; ex[3] = e3;
    for (int i = 0; i < 4; i++) ok[i] = 1'b1;
    if (!skip_wait) wait_mod(1);
    chk({nm, "_view"}, {31'd0, view_res}, {31'd0, ev});
    for (int s = 0; s < 32; s++) begin
      if (s > 0) @(negedge CLK);
      di = s / 8;
      p  = s % 8;
      case (di)
        0:       es = 4'b0111;
        1:       es = 4'b1011;
        2:       es = 4'b1101;
        default: es = 4'b1110;
      endcase
      if (p < 2) begin
        es = 4'b1111;
        eg = GB;
      end else begin
        eg = ex[di];
      end
      if ((seg !== es || a_to_g !== eg) && ok[di]) begin
        ok[di] = 1'b0;
        $display("FAIL %s digit%0d pos%0d: seg=%b a_to_g=%b, want seg=%b a_to_g=%b",
                 nm, di, p, seg, a_to_g, es, eg);
      end
    end
    for (int i = 0; i < 4; i++) begin
      total++;
      if (!ok[i]) bad++;
    end
  endtask

  logic [6:0] p0, p1, p2, p3;

  initial begin
    vecs[0] = '{8'h00, 1'b0, G0, G0, G0, G0};
    vecs[1] = '{8'hF3, 1'b0, G1, G5, G0, G3};
    vecs[2] = '{8'hF3, 1'b1, GM, G1, GB, G3};
    vecs[3] = '{8'h8A, 1'b1, GM, G8, GM, G6};
    vecs[4] = '{8'h9C, 1'b0, G0, G9, G1, G2};
    vecs[5] = '{8'h7E, 1'b1, GB, G7, GM, G2};
    vecs[6] = '{8'h5A, 1'b0, G0, G5, G1, G0};
    vecs[7] = '{8'h0F, 1'b1, GB, G0, GM, G1};

    repeat (3) @(negedge CLK);
    chk("reset_seg", {28'd0, seg}, 32'hF);
    chk("reset_a_to_g", {25'd0, a_to_g}, {25'd0, GB});
    chk("reset_view", {31'd0, view_res}, 32'd0);
    RST = 1'b0;

    // Each vector: change inputs at a frame start, the current frame must
    // still show the previous content, the following frame the new one.
    p0 = G0; p1 = G0; p2 = G0; p3 = G0;
    for (int i = 0; i < 8; i++) begin
      wait_mod(1);
      operands = vecs[i].ops;
      isSigned = vecs[i].sgn;
      check_frame(p0, p1, p2, p3, 1'b0, 1'b1, $sformatf("hold_v%0d", i));
      check_frame(vecs[i].d0, vecs[i].d1, vecs[i].d2, vecs[i].d3, 1'b0,
                  1'b0, $sformatf("vec%0d", i));
      p0 = vecs[i].d0; p1 = vecs[i].d1; p2 = vecs[i].d2; p3 = vecs[i].d3;
    end

    // Result 7 unsigned, held three frames then back to operands.
    wait_mod(1);
    operands = 8'h12;
    isSigned = 1'b0;
    pulse(8'h07, 1'b0);
    check_frame(GB, GB, GB, G7, 1'b1, 1'b0, "res07_f1");
    check_frame(GB, GB, GB, G7, 1'b1, 1'b0, "res07_f2");
    check_frame(GB, GB, GB, G7, 1'b1, 1'b0, "res07_f3");
    check_frame(G0, G1, G0, G2, 1'b0, 1'b0, "res07_back");

    // -128, then a second result during the hold restarts it.
    wait_mod(1);
    isSigned = 1'b1;
    pulse(8'h80, 1'b1);
    check_frame(GM, G1, G2, G8, 1'b1, 1'b0, "res80_f1");
    fork
      check_frame(GM, G1, G2, G8, 1'b1, 1'b0, "res80_f2");
      begin
        @(negedge CLK);
        @(negedge CLK);
        pulse(8'hFF, 1'b1);
      end
    join
    check_frame(GM, GB, GB, G1, 1'b1, 1'b0, "resff_f1");
    check_frame(GM, GB, GB, G1, 1'b1, 1'b0, "resff_f2");
    check_frame(GM, GB, GB, G1, 1'b1, 1'b0, "resff_f3");
    check_frame(GB, G1, GB, G2, 1'b0, 1'b0, "resff_back");

    // Pulse in the boundary cycle wins over an earlier pending result.
    wait_mod(1);
    pulse(8'h05, 1'b0);
    wait_mod(31);
    pulse(8'h2A, 1'b0);
    check_frame(GB, GB, G4, G2, 1'b1, 1'b0, "res_boundary");

    // Reset mid-hold with a pending result that must be discarded.
    wait_mod(1);
    pulse(8'h09, 1'b0);
    repeat (8) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    chk("rst_mid_seg", {28'd0, seg}, 32'hF);
    chk("rst_mid_a_to_g", {25'd0, a_to_g}, {25'd0, GB});
    chk("rst_mid_view", {31'd0, view_res}, 32'd0);
    RST = 1'b0;
    check_frame(G0, G0, G0, G0, 1'b0, 1'b0, "after_rst_f0");
    check_frame(GB, G1, GB, G2, 1'b0, 1'b0, "after_rst_f1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
